// File: rtl/otter_io_pkg.sv
// Shared constants for the OTTER IOBUS responder: window base, register offsets and
// bit positions inside the STATUS and TCTRL registers.
package otter_io_pkg;

  localparam logic [31:0] IO_BASE_DEF = 32'h1100_0000;

  localparam logic [7:0] OFF_SW     = 8'h00;
  localparam logic [7:0] OFF_LED    = 8'h20;
  localparam logic [7:0] OFF_TXDATA = 8'h40;
  localparam logic [7:0] OFF_STATUS = 8'h44;
  localparam logic [7:0] OFF_TCNT   = 8'h60;
  localparam logic [7:0] OFF_TCMP   = 8'h64;
  localparam logic [7:0] OFF_TCTRL  = 8'h68;

  localparam int ST_OVF   = 8;
  localparam int ST_FULL  = 7;
  localparam int ST_EMPTY = 6;
  localparam int ST_CNT_W = 6;

  localparam int TC_PEND  = 2;
  localparam int TC_IRQEN = 1;
  localparam int TC_EN    = 0;

  localparam logic [31:0] TCMP_RST = 32'hFFFF_FFFF;

  // The window is a 256-byte page whose upper half-word matches the base.
  function automatic logic io_hit(input logic [31:0] addr, input logic [15:0] base_hi);
    return (addr[31:16] == base_hi) && (addr[15:8] == 8'h00);
  endfunction

endpackage

// File: rtl/otter_sync_fifo.sv
// Synchronous FIFO with a registered head; zero-latency accept, head visible the cycle after push.
// A push while full is accepted only when a pop happens in the same cycle; otherwise drop_o pulses.
module otter_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_dat_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_dat_o,
  output logic                       head_vld_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    remain;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_pop, do_push;

  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != FULL_CNT) || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    remain   = count_q - CW'(do_pop);
    count_d  = remain + CW'(do_push);
    head_d   = head_q;
    // When the entry being pushed becomes the head it is not in memory yet, so bypass it.
    if (count_d != '0) begin
      head_d = (remain == '0) ? push_dat_i : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  assign head_dat_o = head_q;
  assign head_vld_o = (count_q != '0);
  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign drop_o     = push_i && !do_push;

endmodule

// File: rtl/otter_iobus_responder.sv
// OTTER IOBUS peripheral: switch/LED registers, TX byte FIFO drained by valid/ready, compare timer.
// Loads are combinational from IOBUS_ADDR; stores take effect at the strobe edge; stores to a full FIFO drop.
module otter_iobus_responder
  import otter_io_pkg::*;
#(
  parameter logic [31:0] IO_BASE    = IO_BASE_DEF,
  parameter int          FIFO_DEPTH = 8,
  parameter int          LED_W      = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [31:0]      IOBUS_ADDR,
  input  logic [31:0]      IOBUS_OUT,
  input  logic             IOBUS_WR,
  output logic [31:0]      IOBUS_IN,
  input  logic [LED_W-1:0] SWITCHES,
  output logic [LED_W-1:0] LEDS,
  output logic [7:0]       TX_DATA,
  output logic             TX_VALID,
  input  logic             TX_READY,
  output logic             INTR
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic             hit;
  logic [7:0]       off;
  logic             wr_led, wr_tx, wr_status, wr_tcnt, wr_tcmp, wr_tctrl;

  logic [LED_W-1:0] sw_meta_q, sw_sync_q;
  logic [LED_W-1:0] led_q, led_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      tcnt_q, tcnt_d;
  logic [31:0]      tcmp_q, tcmp_d;
  logic             en_q, en_d;
  logic             irq_en_q, irq_en_d;
  logic             pend_q, pend_d;
  logic             match;

  logic             fifo_full, fifo_empty, fifo_drop;
  logic [CW-1:0]    fifo_count;

  always_comb begin
    hit       = io_hit(IOBUS_ADDR, IO_BASE[31:16]);
    off       = IOBUS_ADDR[7:0];
    wr_led    = IOBUS_WR && hit && (off == OFF_LED);
    wr_tx     = IOBUS_WR && hit && (off == OFF_TXDATA);
    wr_status = IOBUS_WR && hit && (off == OFF_STATUS);
    wr_tcnt   = IOBUS_WR && hit && (off == OFF_TCNT);
    wr_tcmp   = IOBUS_WR && hit && (off == OFF_TCMP);
    wr_tctrl  = IOBUS_WR && hit && (off == OFF_TCTRL);
  end

  otter_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .push_i     (wr_tx),
    .push_dat_i (IOBUS_OUT[7:0]),
    .pop_i      (TX_READY),
    .head_dat_o (TX_DATA),
    .head_vld_o (TX_VALID),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count),
    .drop_o     (fifo_drop)
  );

  always_comb begin
    led_d    = wr_led ? IOBUS_OUT[LED_W-1:0] : led_q;
    ovf_d    = ovf_q;
    if (fifo_drop) begin
      ovf_d = 1'b1;
    end else if (wr_status && IOBUS_OUT[ST_OVF]) begin
      ovf_d = 1'b0;
    end

    tcmp_d   = wr_tcmp ? IOBUS_OUT : tcmp_q;
    en_d     = wr_tctrl ? IOBUS_OUT[TC_EN] : en_q;
    irq_en_d = wr_tctrl ? IOBUS_OUT[TC_IRQEN] : irq_en_q;
    match    = en_q && (tcnt_q == tcmp_q);
    tcnt_d   = tcnt_q;
    pend_d   = pend_q;
    if (wr_tcnt) begin
      tcnt_d = IOBUS_OUT;
    end else if (match) begin
      tcnt_d = '0;
    end else if (en_q) begin
      tcnt_d = tcnt_q + 32'd1;
    end
    // A compare hit outranks a software clear landing in the same cycle.
    if (match && !wr_tcnt) begin
      pend_d = 1'b1;
    end else if (wr_tctrl && IOBUS_OUT[TC_PEND]) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      led_q     <= '0;
      ovf_q     <= 1'b0;
      tcnt_q    <= '0;
      tcmp_q    <= TCMP_RST;
      en_q      <= 1'b0;
      irq_en_q  <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      sw_meta_q <= SWITCHES;
      sw_sync_q <= sw_meta_q;
      led_q     <= led_d;
      ovf_q     <= ovf_d;
      tcnt_q    <= tcnt_d;
      tcmp_q    <= tcmp_d;
      en_q      <= en_d;
      irq_en_q  <= irq_en_d;
      pend_q    <= pend_d;
    end
  end

  always_comb begin
    IOBUS_IN = '0;
    if (hit) begin
      case (off)
        OFF_SW:     IOBUS_IN[LED_W-1:0] = sw_sync_q;
        OFF_LED:    IOBUS_IN[LED_W-1:0] = led_q;
        OFF_STATUS: begin
          IOBUS_IN[ST_OVF]         = ovf_q;
          IOBUS_IN[ST_FULL]        = fifo_full;
          IOBUS_IN[ST_EMPTY]       = fifo_empty;
          IOBUS_IN[ST_CNT_W-1:0]   = ST_CNT_W'(fifo_count);
        end
        OFF_TCNT:   IOBUS_IN = tcnt_q;
        OFF_TCMP:   IOBUS_IN = tcmp_q;
        OFF_TCTRL:  begin
          IOBUS_IN[TC_PEND]  = pend_q;
          IOBUS_IN[TC_IRQEN] = irq_en_q;
          IOBUS_IN[TC_EN]    = en_q;
        end
        default:    IOBUS_IN = '0;
      endcase
    end
  end

  assign LEDS = led_q;
  assign INTR = pend_q && irq_en_q;

endmodule
